cpu_ctrl: RTL

Instruction register plus Moore control FSM for the lab CPU. Sits directly upstream of the 8×16 register file and datapath. It latches a 16-bit instruction and decodes it. It then sequences the register-file controls (readnum, writenum, write), the A/B/C/status load enables and the operand selects, one microstep per clock. A start/wait handshake lets the host or testbench issue one instruction at a time.

---
 rtl/cpu_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl.sv
// Instruction register and Moore control FSM for the lab CPU.
// It latches one instruction per start handshake and then sequences the register-file and datapath controls one microstep per clock.
module cpu_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_RD  = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;

  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [1:0]  sh;
  logic [2:0]  rm;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  logic is_mov_imm;
  logic is_mov_reg;
  logic is_arith;
  logic is_cmp;
  logic is_mvn;
  logic is_legal;

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_arith   = (opcode == 3'b101) && (op != 2'b11);
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  assign is_legal   = is_mov_imm || is_mov_reg || is_arith || is_mvn;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_WAIT;
    else          state <= state_nxt;
  end

  // IR only accepts a new word while idle, so a running instruction is never disturbed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       ir <= 16'h0000;
    else if ((state == S_WAIT) && load) ir <= instr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           err <= 1'b0;
    else if ((state == S_WAIT) && s)        err <= 1'b0;
    else if ((state == S_DECODE) && !is_legal) err <= 1'b1;
  end

  always_comb begin
    state_nxt = state;
    w         = 1'b0;
    readnum   = 3'b000;
    writenum  = 3'b000;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = 2'b00;
    shift     = 2'b00;
    ALUop     = 2'b00;
    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)                 state_nxt = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn)  state_nxt = S_GET_B;
        else if (is_arith)              state_nxt = S_GET_A;
        else                            state_nxt = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum  = rn;
        vsel      = 2'b10;
        write     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_GET_A: begin
        readnum   = rn;
        loada     = 1'b1;
        state_nxt = S_GET_B;
      end
      S_GET_B: begin
        readnum   = rm;
        loadb     = 1'b1;
        state_nxt = S_ALU;
      end
      S_ALU: begin
        shift = sh;
        ALUop = (opcode == 3'b101) ? op : 2'b00;
        // MOV reg and MVN are single-operand: A is forced to zero.
        asel  = is_mov_reg || is_mvn;
        if (is_cmp) begin
          loads     = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          loadc     = 1'b1;
          state_nxt = S_WRITE_RD;
        end
      end
      S_WRITE_RD: begin
        writenum  = rd;
        vsel      = 2'b00;
        write     = 1'b1;
        state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

endmodule
